// File: rtl/ws2812_rx.sv
// Purpose : decode a raw WS2812 line into bytes (MSB first) with per-frame byte index and frame delimiting.
// Latency : out_valid on the 4th clk edge after the 8th bit's falling edge (2 sync + 1 edge detect + 1 output reg).
// Backpressure: none; the line cannot be stalled, so every output is a single-cycle pulse.
//
// Ports:
//   clk, rst     block clock, asynchronous active-low reset
//   din          raw WS2812 line, asynchronous to clk
//   out_data/out_valid/out_addr   received byte, its strobe and its index within the frame
//   frame_start  pulse on the first rising edge after a gap
//   frame_done   pulse when the reset gap ends a frame; frame_bytes loaded in the same cycle
//   err          pulse on glitch, overlong high, partial byte at frame end, or index overflow
module ws2812_rx #(
    parameter int BIT_THRESHOLD = 14,
    parameter int MIN_HIGH      = 3,
    parameter int MAX_HIGH      = 48,
    parameter int RESET_CYCLES  = 1200,
    parameter int ADDR_W        = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic [ADDR_W-1:0] frame_bytes,
    output logic              err
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  C_THR   = CNT_W'(BIT_THRESHOLD);
    localparam logic [CNT_W-1:0]  C_MIN   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0]  C_MAX   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0]  C_RST   = CNT_W'(RESET_CYCLES);
    localparam logic [ADDR_W-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t            state;
    logic              din_s1;
    logic              din_s2;
    logic              din_s3;
    logic              rise_p;
    logic              fall_p;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q;
    logic [7:0]        shift_nxt;
    logic              bit_val;
    logic [ADDR_W-1:0] idx;
    logic              idx_full;   // byte at IDX_MAX already emitted; later bytes are dropped
    logic              ovf_seen;   // overflow err already pulsed in this frame
    logic [ADDR_W-1:0] byte_count;

    // Synchroniser plus edge detect. The edges are registered so that rise and
    // fall reach the FSM with the same delay and pulse widths measure true.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
            din_s3 <= 1'b0;
            rise_p <= 1'b0;
            fall_p <= 1'b0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
            din_s3 <= din_s2;
            rise_p <= din_s2 & ~din_s3;
            fall_p <= ~din_s2 & din_s3;
        end
    end

    // cnt_inc is the number of cycles spent in the current phase including this one.
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign bit_val    = (cnt_inc >= C_THR);
    assign shift_nxt  = {shift_q[6:0], bit_val};
    assign byte_count = idx_full ? IDX_MAX : idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            idx         <= '0;
            idx_full    <= 1'b0;
            ovf_seen    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_bytes <= '0;
            err         <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;

            case (state)
                // Hold off until a full reset gap so decoding starts on a frame boundary.
                SYNC: begin
                    if (din_s2) begin
                        cnt <= '0;
                    end else if (cnt_inc >= C_RST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                IDLE: begin
                    if (rise_p) begin
                        state       <= HIGH;
                        cnt         <= '0;
                        frame_start <= 1'b1;
                    end
                end

                HIGH: begin
                    if (fall_p) begin
                        if (cnt_inc < C_MIN) begin
                            err      <= 1'b1;
                            state    <= SYNC;
                            cnt      <= '0;
                            bit_cnt  <= '0;
                            idx      <= '0;
                            idx_full <= 1'b0;
                            ovf_seen <= 1'b0;
                        end else begin
                            state   <= LOW;
                            cnt     <= '0;
                            shift_q <= shift_nxt;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (!idx_full) begin
                                    out_valid <= 1'b1;
                                    out_data  <= shift_nxt;
                                    out_addr  <= idx;
                                    if (idx == IDX_MAX)
                                        idx_full <= 1'b1;
                                    else
                                        idx <= idx + 1'b1;
                                end else if (!ovf_seen) begin
                                    err      <= 1'b1;
                                    ovf_seen <= 1'b1;
                                end
                            end
                        end
                    end else if (cnt_inc >= C_MAX) begin
                        // Still high after MAX_HIGH cycles, so the pulse is
                        // already longer than MAX_HIGH.
                        err      <= 1'b1;
                        state    <= SYNC;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        idx      <= '0;
                        idx_full <= 1'b0;
                        ovf_seen <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                LOW: begin
                    if (rise_p) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt_inc >= C_RST) begin
                        // Frame gap: a trailing partial byte is discarded and flagged.
                        state       <= IDLE;
                        cnt         <= '0;
                        frame_done  <= 1'b1;
                        frame_bytes <= byte_count;
                        err         <= (bit_cnt != 3'd0);
                        bit_cnt     <= '0;
                        idx         <= '0;
                        idx_full    <= 1'b0;
                        ovf_seen    <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state <= SYNC;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Purpose : directed-vector bench for ws2812_rx; expected pulses queued by stimulus, checked by a monitor.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
`timescale 1ns/1ps
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [11:0] out_addr;
    logic        frame_start;
    logic        frame_done;
    logic [11:0] frame_bytes;
    logic        err;

    ws2812_rx dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_bytes (frame_bytes),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Event flags packed as {frame_start, out_valid, frame_done, err}.
    localparam logic [3:0] F_START = 4'b1000;
    localparam logic [3:0] F_BYTE  = 4'b0100;
    localparam logic [3:0] F_DONE  = 4'b0010;
    localparam logic [3:0] F_ERR   = 4'b0001;

    typedef struct {
        logic [3:0]  flags;
        logic [7:0]  data;
        logic [11:0] addr;
        logic [11:0] nbytes;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void push(input logic [3:0] f, input logic [7:0] d,
                                 input logic [11:0] a, input logic [11:0] n);
        exp_t e;
        e.flags  = f;
        e.data   = d;
        e.addr   = a;
        e.nbytes = n;
        q.push_back(e);
    endfunction

    // Monitor: any pulse output must match the next queued expectation.
    always @(negedge clk) begin : monitor
        logic [3:0] act;
        exp_t       e;
        act = {frame_start, out_valid, frame_done, err};
        if (act != 4'b0000) begin
            if (q.size() == 0) begin
                chk("unexpected_event", 32'(act), 32'd0);
            end else begin
                e = q.pop_front();
                chk("event_kind", 32'(act), 32'(e.flags));
                if (e.flags == F_BYTE) begin
                    chk("byte_data", 32'(out_data), 32'(e.data));
                    chk("byte_addr", 32'(out_addr), 32'(e.addr));
                end
                if (e.flags[1])
                    chk("frame_bytes", 32'(frame_bytes), 32'(e.nbytes));
            end
        end
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int period);
        int h;
        h = b ? 19 : 10;
        hold(1'b1, h);
        hold(1'b0, period - h);
    endtask

    task automatic send_byte(input logic [7:0] v, input int period);
        for (int i = 7; i >= 0; i--) send_bit(v[i], period);
    endtask

    // One clean single-byte frame followed by a gap.
    task automatic frame1(input logic [7:0] v);
        push(F_START, 8'h00, 12'd0, 12'd0);
        push(F_BYTE, v, 12'd0, 12'd0);
        push(F_DONE, 8'h00, 12'd0, 12'd1);
        send_byte(v, 30);
        hold(1'b0, 1250);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_out_data",    32'(out_data),    32'd0);
        chk("rst_out_addr",    32'(out_addr),    32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_frame_done",  32'(frame_done),  32'd0);
        chk("rst_frame_bytes", 32'(frame_bytes), 32'd0);
        chk("rst_err",         32'(err),         32'd0);
        rst = 1'b1;
        hold(1'b0, 1250);

        // Single byte 0xA5.
        frame1(8'hA5);

        // 336 incrementing bytes at a shorter bit period.
        push(F_START, 8'h00, 12'd0, 12'd0);
        for (int i = 0; i < 336; i++) push(F_BYTE, 8'(i), 12'(i), 12'd0);
        push(F_DONE, 8'h00, 12'd0, 12'd336);
        for (int i = 0; i < 336; i++) send_byte(8'(i), 22);
        hold(1'b0, 1250);

        // 12 bits: one whole byte, then partial byte flagged together with frame_done.
        push(F_START, 8'h00, 12'd0, 12'd0);
        push(F_BYTE, 8'h96, 12'd0, 12'd0);
        push(F_DONE | F_ERR, 8'h00, 12'd0, 12'd1);
        send_byte(8'h96, 30);
        send_bit(1'b1, 30);
        send_bit(1'b0, 30);
        send_bit(1'b1, 30);
        send_bit(1'b1, 30);
        hold(1'b0, 1250);

        // 1-cycle glitch mid-byte, then recovery after a gap.
        push(F_START, 8'h00, 12'd0, 12'd0);
        push(F_ERR, 8'h00, 12'd0, 12'd0);
        send_bit(1'b1, 30);
        send_bit(1'b0, 30);
        send_bit(1'b0, 30);
        send_bit(1'b1, 30);
        hold(1'b1, 1);
        hold(1'b0, 1300);
        frame1(8'h5A);

        // Reset after 4 bits: no pulses, next frame decodes from addr 0.
        push(F_START, 8'h00, 12'd0, 12'd0);
        send_bit(1'b1, 30);
        send_bit(1'b1, 30);
        send_bit(1'b0, 30);
        send_bit(1'b0, 30);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold(1'b0, 1250);
        frame1(8'hC3);

        // Line held high through reset release: nothing until a full gap is seen.
        rst = 1'b0;
        din = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold(1'b1, 300);
        hold(1'b0, 1250);
        frame1(8'h3C);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
